// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Operation encodings follow funct3 directly so the decode is a plain cast.
package mdu_pkg;

  localparam int MDU_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } mdu_state_t;

  function automatic logic op_signed_a(input mdu_op_t op);
    return !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  endfunction

  function automatic logic op_signed_b(input mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the finished product, quotient or remainder.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/multicycle_mdu.sv
// Iterative RV32M multiply/divide: MSB-first shift-add multiply and restoring
// divide, one bit per cycle, fixed 33-cycle latency from the start edge.
module multicycle_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDUResult
);

  mdu_state_t        state_reg, state_next;
  mdu_op_t           op_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [4:0]        count_reg;
  logic              neg_reg;
  logic              override_reg;
  logic [XLEN-1:0]   override_val_reg;
  logic [XLEN-1:0]   result_reg;

  logic              accept;
  mdu_op_t           op_in;
  logic              is_rem_in;
  logic              div_zero_in;
  logic              overflow_in;
  logic              override_in;
  logic [XLEN-1:0]   override_val_in;
  logic              neg_in;

  logic [XLEN-1:0]   op_raw  [2];
  logic              op_sign [2];
  logic [XLEN-1:0]   op_mag  [2];

  logic              a_bit;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   rem_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] acc_next;

  logic [2*XLEN-1:0] fix_in;
  logic [2*XLEN-1:0] fix_out;
  logic [XLEN-1:0]   result_next;

  // ---------------------------------------------------------------- decode
  assign accept    = start && (state_reg == IDLE || state_reg == DONE);
  assign op_in     = mdu_op_t'(funct3);
  assign is_rem_in = op_is_rem(op_in);

  assign op_raw[0]  = SrcA;
  assign op_raw[1]  = SrcB;
  assign op_sign[0] = op_signed_a(op_in) & SrcA[XLEN-1];
  assign op_sign[1] = op_signed_b(op_in) & SrcB[XLEN-1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opfix
      mdu_signfix #(.W(XLEN)) u_opfix (
        .neg    (op_sign[gi]),
        .value  (op_raw[gi]),
        .result (op_mag[gi])
      );
    end
  endgenerate

  // Divide special cases are resolved at start; the iteration still runs.
  assign div_zero_in = (SrcB == '0);
  assign overflow_in = (op_in == OP_DIV || op_in == OP_REM)
                       && (SrcA == {1'b1, {(XLEN-1){1'b0}}})
                       && (SrcB == '1);
  assign override_in = funct3[2] & (div_zero_in | overflow_in);

  always_comb begin
    override_val_in = '0;
    if (div_zero_in) begin
      override_val_in = is_rem_in ? SrcA : '1;
    end else if (!is_rem_in) begin
      override_val_in = SrcA;
    end
  end

  assign neg_in = is_rem_in ? op_sign[0] : (op_sign[0] ^ op_sign[1]);

  // ------------------------------------------------------------ iteration
  always_comb begin
    a_bit     = a_reg[count_reg];
    mul_step  = {acc_reg[2*XLEN-2:0], 1'b0}
                + (a_bit ? {{XLEN{1'b0}}, b_reg} : {(2*XLEN){1'b0}});
    rem_shift = {acc_reg[2*XLEN-1:XLEN], a_bit};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
    q_bit     = ~rem_diff[XLEN+1];
    div_step  = {(q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                 acc_reg[XLEN-2:0], q_bit};
    acc_next  = op_reg[2] ? div_step : mul_step;
  end

  // ---------------------------------------------------------------- fixup
  always_comb begin
    fix_in = acc_reg;
    case (op_reg)
      OP_DIV, OP_DIVU: fix_in = {{XLEN{1'b0}}, acc_reg[XLEN-1:0]};
      OP_REM, OP_REMU: fix_in = {{XLEN{1'b0}}, acc_reg[2*XLEN-1:XLEN]};
      default:         fix_in = acc_reg;
    endcase
  end

  mdu_signfix #(.W(2*XLEN)) u_resfix (
    .neg    (neg_reg),
    .value  (fix_in),
    .result (fix_out)
  );

  always_comb begin
    result_next = fix_out[XLEN-1:0];
    if (op_reg inside {OP_MULH, OP_MULHSU, OP_MULHU}) begin
      result_next = fix_out[2*XLEN-1:XLEN];
    end
    if (override_reg) begin
      result_next = override_val_reg;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count_reg == '0) state_next = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg           <= OP_MUL;
      a_reg            <= '0;
      b_reg            <= '0;
      acc_reg          <= '0;
      count_reg        <= '0;
      neg_reg          <= 1'b0;
      override_reg     <= 1'b0;
      override_val_reg <= '0;
      result_reg       <= '0;
    end else if (accept) begin
      op_reg           <= op_in;
      a_reg            <= op_mag[0];
      b_reg            <= op_mag[1];
      acc_reg          <= '0;
      count_reg        <= 5'(MDU_ITERS - 1);
      neg_reg          <= neg_in;
      override_reg     <= override_in;
      override_val_reg <= override_val_in;
    end else if (state_reg == CALC) begin
      acc_reg <= acc_next;
      if (count_reg != '0) begin
        count_reg <= count_reg - 5'd1;
      end
    end else if (state_reg == FIXUP) begin
      result_reg <= result_next;
    end
  end

  assign MDUResult = result_reg;

endmodule

// File: tb/tb_multicycle_mdu.sv
// Scoreboard bench for multicycle_mdu: stimulus pushes expected results with
// their due cycle, a monitor pops and compares on every done pulse.
module tb_multicycle_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy;
  logic        done;
  logic [31:0] MDUResult;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  multicycle_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .busy      (busy),
    .done      (done),
    .MDUResult (MDUResult)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected transaction.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done cycle=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, MDUResult, mon_e.res);
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
        check({mon_e.name, "_busy_low"}, 32'(busy), 32'd0);
        $display("op %s result=%h expected=%h cycle=%0d", mon_e.name, MDUResult, mon_e.res, cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input string name, output int e0);
    start  = 1'b1;
    funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    e0     = cyc + 1;
    sb.push_back('{res: exp_res, due: e0 + 33, name: name});
    @(posedge clk); #2;
    start  = 1'b0;
    SrcA   = $urandom;
    SrcB   = $urandom;
    funct3 = 3'($urandom);
  endtask

  task automatic wait_drain(input int e0);
    int k = 0;
    while (sb.size() != 0 && k < 45) begin
      @(posedge clk); #2;
      k++;
      if (cyc == e0 + 1 || cyc == e0 + 32) begin
        check("busy_during_op", 32'(busy), 32'd1);
        check("done_during_op", 32'(done), 32'd0);
      end
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending_%0d required=drained", sb.size());
      sb.delete();
    end
    @(posedge clk); #2;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input string name);
    int e0;
    issue(f3, a, b, exp_res, name, e0);
    wait_drain(e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int k;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", MDUResult, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // MUL with a spurious start (DIVU 100/7) at E5 that must be ignored.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", e0);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1; funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #2;
    start = 1'b0;
    wait_drain(e0);

    run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
    run(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
    run(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    run(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    run(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         "rem_7_m2");
    run(3'b101, 32'd100,       32'd7,         32'd14,        "divu_100_7");
    run(3'b111, 32'd100,       32'd7,         32'd2,         "remu_100_7");
    run(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0");
    run(3'b110, 32'd5,         32'd0,         32'd5,         "rem_5_0");
    run(3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_0");
    run(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_m7_0");
    run(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");

    // Asynchronous reset in the middle of a MULHU aborts it.
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu_aborted", e0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", MDUResult, 32'd0);
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_after_rst");

    // Back-to-back: start held through the DONE cycle of MUL 6x7.
    start = 1'b1; funct3 = 3'b000; SrcA = 32'd6; SrcB = 32'd7;
    e0 = cyc + 1;
    sb.push_back('{res: 32'd42, due: e0 + 33, name: "b2b_mul_6_7"});
    sb.push_back('{res: 32'd3,  due: e0 + 67, name: "b2b_divu_9_3"});
    @(posedge clk); #2;
    funct3 = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
    k = 0;
    while (sb.size() != 0 && k < 80) begin
      @(posedge clk); #2;
      k++;
      if (cyc == e0 + 34) begin
        start = 1'b0;
        check("b2b_busy_rises", 32'(busy), 32'd1);
        check("b2b_done_falls", 32'(done), 32'd0);
      end
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout actual=pending_%0d required=drained", sb.size());
      sb.delete();
    end
    @(posedge clk); #2;
    check("b2b_done_one_cycle", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_mdu.md
# multicycle_mdu

Iterative RV32M multiply/divide unit for the multicycle datapath. Accepts two 32-bit operands and a funct3 selector, computes one result bit per cycle (shift-add multiply, restoring divide), and presents a registered 32-bit result with a one-cycle done pulse. The result is captured by the ALU result register in the same way as the ordinary ALU output. The control FSM stalls on `busy` while the unit runs.

## Interface

Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation. Sampled only in IDLE or DONE.
- `funct3` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA` input 32: multiplicand or dividend.
- `SrcB` input 32: multiplier or divisor.
- `busy` output 1: high while CALC or FIXUP.
- `done` output 1: one-cycle pulse when `MDUResult` is valid.
- `MDUResult` output 32: registered result. Held until the next operation completes.

## Operation

States:
- IDLE: wait for `start`.
- CALC: one iteration per cycle.
- FIXUP: apply sign correction and select the result half.
- DONE: `done`=1 for this one cycle.

Start and transitions:
- On `start` in IDLE or DONE, register `funct3`, the operand magnitudes, and the result sign flags, clear the 64-bit accumulator, load `count`=31, and go to CALC.
- In DONE without `start`, go to IDLE.
- Signedness of operands:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: only `SrcA` signed.
  - MULHU/DIVU/REMU: unsigned.
- CALC: one shift-add or restore-subtract step per cycle. When `count`=0, go to FIXUP. Otherwise decrement `count`.
- FIXUP:
  - Negate the product, quotient or remainder as required.
  - Register the result: MUL takes the low 32 bits, MULH/MULHSU/MULHU take the high 32 bits, DIV/DIVU take the quotient, REM/REMU take the remainder. Go to DONE.

Arithmetic rules:
- Product sign = signA XOR signB.
- Quotient sign = signA XOR signB.
- Remainder sign = dividend sign, so truncating division.
- Divide by zero: quotient = 0xFFFFFFFF for DIV and DIVU. Remainder = `SrcA` unmodified.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
- Both special cases still take the full fixed latency. They are detected at start and override the result in FIXUP.

Boundary conditions:
- `start` during CALC or FIXUP is ignored. Operands and funct3 are not re-sampled.
- Reset mid-operation aborts. State returns to IDLE and all outputs go to 0.
- `SrcA` and `SrcB` may change after the start cycle without affecting the result.

## Timing

- Reset values: `busy`=0, `done`=0, `MDUResult`=0, state IDLE, `count`=0, accumulator 0.
- Start is accepted at edge E0. State is CALC during E1..E32, the 32 iterations.
- FIXUP follows E32. `MDUResult` is written at E33.
- DONE/`done` is high from E33 to E34. `busy` is high from E0 to E33.
- Latency is fixed for every funct3 and operand value: result visible 33 cycles after the start edge.
- Back-to-back: `start` during the DONE cycle is accepted at E34. `done` falls and `busy` rises at the same edge, with no idle bubble.
- No combinational path from any input to any output.

## Structure

- Shared package `mdu_pkg`:
  - `mdu_op_t` enum for the eight funct3 encodings.
  - `mdu_state_t` enum {IDLE, CALC, FIXUP, DONE}.
  - Constant `MDU_ITERS`=32.
- Helper `mdu_signfix`: a combinational conditional two's-complement negate, instantiated for operand magnitude and result correction.
- Everything else lives in one module. Datapath:
  - 64-bit accumulator: product, or {remainder, quotient}.
  - 32-bit divisor/multiplicand register.
  - 5-bit counter.

## Test plan

- MUL 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB. `done` pulses exactly one cycle, 33 cycles after the start edge. `busy` is high from the start edge to the `done` edge.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD, and REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14, and REMU → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF, and REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM → 0.
  - All with the 33-cycle latency.
- `start` pulsed with new operands at E5 → ignored, first result unchanged. Assert `rst` at E10 → `busy`/`done`/`MDUResult` = 0 immediately, and a fresh MULHU starts and completes normally.
- Hold `start` into the DONE cycle with a DIVU 9/3 following a MUL 6×7 → 42 then 3. Second `done` comes exactly 34 cycles after the first.
